udp_recv_dram: RTL and testbench



---
 rtl/udp_stream_pkg.sv | 28 ++
 rtl/pkt_buf_ram.sv | 31 +++
 rtl/udp_recv_dram.sv | 180 ++++++++++++++++++
 tb/tb_udp_recv_dram.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_stream_pkg.sv
// Constants and state encoding shared by the stream UDP sender and receiver.
package udp_stream_pkg;

  localparam int AMOUNT_OF_ONCE = 256;        // payload words per packet
  localparam int HDR_WORDS      = 4;          // header words ahead of the info word
  localparam int HDR_PORT_IDX   = 2;          // header word carrying the destination port
  localparam int HDR_SIZE_IDX   = 3;          // header word carrying the byte size
  localparam int INFO_BYTES     = 4;          // info word counted in the size field
  localparam logic [15:0] PORT  = 16'h4000;   // stream destination port
  localparam int EOF_BIT        = 31;         // end-of-frame flag in the info word

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_INFO,
    S_PAYLOAD,
    S_DROP,
    S_KICK,
    S_DRAM_WAIT,
    S_FRAMESWITCH
  } state_t;

  // Size field a well-formed packet must carry: payload bytes plus the info word.
  function automatic logic [31:0] pkt_size_bytes(input int amount);
    return 32'(amount * 4 + INFO_BYTES);
  endfunction

endpackage

// File: rtl/pkt_buf_ram.sv
// One-packet payload buffer: simple dual-port RAM, synchronous read, 1-cycle latency.
module pkt_buf_ram
  import udp_stream_pkg::*;
#(
  parameter int DEPTH = AMOUNT_OF_ONCE,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Write port: no reset, contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: registered output, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/udp_recv_dram.sv
// Receives fixed-size stream UDP packets, validates header/size, buffers the
// payload in one packet of RAM and hands it to the DRAM write engine.
//
// Handshakes: a packet is offered as a contiguous run of r_enable-high words;
// the block only starts one while r_ack is high (s_idle) and only after it has
// seen r_enable low there. wr_kick is a one-cycle start pulse issued only while
// wr_busy is low; each wr_re pulse returns one payload word on wr_data in the
// following cycle.
module udp_recv_dram #(
  parameter int          AMOUNT_OF_ONCE = udp_stream_pkg::AMOUNT_OF_ONCE,
  parameter logic [15:0] RX_PORT        = udp_stream_pkg::PORT,
  parameter int          ADDR_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r_req,
  output logic                  r_ack,
  input  logic                  r_enable,
  input  logic [31:0]           r_data,
  output logic                  wr_kick,
  input  logic                  wr_busy,
  output logic [31:0]           wr_num,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic                  wr_re,
  output logic [31:0]           wr_data,
  output logic                  frame_select,
  output logic [15:0]           pkt_ok_cnt,
  output logic [15:0]           pkt_drop_cnt,
  output logic [2:0]            state_dbg
);
  import udp_stream_pkg::*;

  localparam int            CW       = $clog2(AMOUNT_OF_ONCE);
  localparam logic [CW-1:0] LAST     = CW'(AMOUNT_OF_ONCE - 1);
  localparam logic [31:0]   PKT_SIZE = pkt_size_bytes(AMOUNT_OF_ONCE);

  state_t        state;
  logic [1:0]    hdr_cnt;
  logic [15:0]   hdr_port;
  logic [31:0]   hdr_size;
  logic [CW-1:0] cnt;
  logic [CW-1:0] rd_ptr;
  logic          eof;
  logic          armed;       // r_enable seen low in s_idle since the last packet
  logic          wait_first;  // first s_dram_wait cycle, wr_busy not yet meaningful
  logic          hdr_ok;
  logic          ram_we;
  logic          unused_r_req;

  // r_req only announces what r_enable already delivers.
  assign unused_r_req = r_req;

  assign wr_num    = 32'(AMOUNT_OF_ONCE);
  assign state_dbg = state;
  assign hdr_ok    = (hdr_port == RX_PORT) && (hdr_size == PKT_SIZE);
  assign ram_we    = (state == S_PAYLOAD) && r_enable;

  pkt_buf_ram #(.DEPTH(AMOUNT_OF_ONCE), .AW(CW)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (cnt),
    .wdata (r_data),
    .re    (wr_re),
    .raddr (rd_ptr),
    .rdata (wr_data)
  );

  // Packet receive / commit state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      r_ack        <= 1'b1;
      wr_kick      <= 1'b0;
      wr_addr      <= '0;
      frame_select <= 1'b0;
      pkt_ok_cnt   <= '0;
      pkt_drop_cnt <= '0;
      hdr_cnt      <= '0;
      hdr_port     <= '0;
      hdr_size     <= '0;
      cnt          <= '0;
      rd_ptr       <= '0;
      eof          <= 1'b0;
      armed        <= 1'b0;
      wait_first   <= 1'b0;
    end else begin
      if (wr_re) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;

      case (state)
        S_IDLE: begin
          if (!r_enable) begin
            armed <= 1'b1;
          end else if (armed) begin
            // This word is header 0; its contents are not needed.
            armed   <= 1'b0;
            hdr_cnt <= 2'd1;
            r_ack   <= 1'b0;
            state   <= S_HEADER;
          end
        end
        S_HEADER: begin
          if (!r_enable) begin
            pkt_drop_cnt <= pkt_drop_cnt + 16'd1;
            state        <= S_DROP;
          end else begin
            if (hdr_cnt == 2'(HDR_PORT_IDX)) hdr_port <= r_data[15:0];
            if (hdr_cnt == 2'(HDR_SIZE_IDX)) begin
              hdr_size <= r_data;
              state    <= S_INFO;
            end
            hdr_cnt <= hdr_cnt + 2'd1;
          end
        end
        S_INFO: begin
          if (r_enable && hdr_ok) begin
            wr_addr <= ADDR_WIDTH'(r_data[EOF_BIT-1:0]);
            eof     <= r_data[EOF_BIT];
            cnt     <= '0;
            state   <= S_PAYLOAD;
          end else begin
            pkt_drop_cnt <= pkt_drop_cnt + 16'd1;
            state        <= S_DROP;
          end
        end
        S_PAYLOAD: begin
          if (!r_enable) begin
            pkt_drop_cnt <= pkt_drop_cnt + 16'd1;
            state        <= S_DROP;
          end else if (cnt == LAST) begin
            // Kick right away when the engine is free so it lands the cycle after the last word.
            rd_ptr  <= '0;
            wr_kick <= !wr_busy;
            state   <= S_KICK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DROP: begin
          if (!r_enable) begin
            r_ack <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_KICK: begin
          if (wr_kick) begin
            wr_kick    <= 1'b0;
            wait_first <= 1'b1;
            state      <= S_DRAM_WAIT;
          end else if (!wr_busy) begin
            wr_kick <= 1'b1;
          end
        end
        S_DRAM_WAIT: begin
          wait_first <= 1'b0;
          if (!wait_first && !wr_busy) begin
            pkt_ok_cnt <= pkt_ok_cnt + 16'd1;
            if (eof) begin
              // Flip on the way in so the change lands one cycle after busy falls.
              frame_select <= ~frame_select;
              state        <= S_FRAMESWITCH;
            end else begin
              r_ack <= 1'b1;
              state <= S_IDLE;
            end
          end
        end
        S_FRAMESWITCH: begin
          r_ack <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          r_ack <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_udp_recv_dram.sv
// Bench for udp_recv_dram: random packets, DRAM engine model, scoreboard queues.
module tb_udp_recv_dram;

  localparam int          N        = 256;
  localparam logic [15:0] GOOD_PORT = 16'h4000;
  localparam logic [31:0] GOOD_SIZE = 32'h0000_0404;
  // 1 + 4 + 1 + N cycles counted inclusively from the first word, i.e. N+5 edges later.
  localparam int          KICK_LAT = 1 + 4 + 1 + N - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r_req = 1'b0;
  logic        r_ack;
  logic        r_enable = 1'b0;
  logic [31:0] r_data = '0;
  logic        wr_kick;
  logic        wr_busy;
  logic [31:0] wr_num;
  logic [31:0] wr_addr;
  logic        wr_re;
  logic [31:0] wr_data;
  logic        frame_select;
  logic [15:0] pkt_ok_cnt;
  logic [15:0] pkt_drop_cnt;
  logic [2:0]  state_dbg;

  logic eng_busy = 1'b0;
  logic tb_busy  = 1'b0;
  logic eng_re   = 1'b0;
  assign wr_busy = eng_busy | tb_busy;
  assign wr_re   = eng_re;

  udp_recv_dram dut (
    .clk          (clk),
    .rst          (rst),
    .r_req        (r_req),
    .r_ack        (r_ack),
    .r_enable     (r_enable),
    .r_data       (r_data),
    .wr_kick      (wr_kick),
    .wr_busy      (wr_busy),
    .wr_num       (wr_num),
    .wr_addr      (wr_addr),
    .wr_re        (wr_re),
    .wr_data      (wr_data),
    .frame_select (frame_select),
    .pkt_ok_cnt   (pkt_ok_cnt),
    .pkt_drop_cnt (pkt_drop_cnt),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [0:0]  exp_eof_q[$];

  int   exp_ok   = 0;
  int   exp_drop = 0;
  logic exp_fs   = 1'b0;

  int kick_cnt  = 0;
  int kick_cyc  = 0;
  int start_cyc = 0;
  bit eng_active = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor: DRAM write engine model ----------------
  initial begin : monitor
    logic [31:0] e_addr;
    logic [31:0] e_word;
    logic [0:0]  e_eof;
    logic        fs_before;
    int          hold;
    forever begin
      @(negedge clk);
      if (wr_kick === 1'b1 && rst === 1'b0) begin
        kick_cnt++;
        kick_cyc   = cyc;
        eng_active = 1'b1;
        if (exp_addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_kick actual=kick at addr %0h required=no kick", wr_addr);
          eng_active = 1'b0;
        end else begin
          e_addr = exp_addr_q.pop_front();
          e_eof  = exp_eof_q.pop_front();
          check("kick_addr", wr_addr, e_addr);
          check("wr_num", wr_num, 32'(N));
          eng_busy = 1'b1;
          hold = $urandom_range(0, 5);
          repeat (hold) @(negedge clk);
          for (int i = 0; i <= N; i++) begin
            @(negedge clk);
            if (i > 0) begin
              if (exp_data_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL data_underflow actual=%0h required=no word", wr_data);
              end else begin
                e_word = exp_data_q.pop_front();
                check("wr_data", wr_data, e_word);
              end
            end
            eng_re = (i < N);
          end
          fs_before = frame_select;
          eng_busy  = 1'b0;
          @(negedge clk);
          check("frame_select_after_busy", 32'(frame_select), 32'(fs_before ^ e_eof[0]));
          eng_active = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [31:0] w);
    @(negedge clk);
    r_enable = 1'b1;
    r_data   = w;
  endtask

  task automatic wait_ack();
    int t = 0;
    while (r_ack !== 1'b1 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout actual=%0b required=1", r_ack);
    end
  endtask

  // Drives one packet; the reference model decides commit or drop from the packet rules.
  task automatic send_pkt(input logic [15:0] port, input logic [31:0] size,
                          input logic [31:0] info, input int n_pay,
                          input int extra, input bit index_data);
    logic [31:0] pay[$];
    bit valid;
    wait_ack();
    r_enable = 1'b0;
    repeat (2) @(negedge clk);
    valid = (port == GOOD_PORT) && (size == GOOD_SIZE) && (n_pay >= N);
    for (int i = 0; i < n_pay; i++) pay.push_back(index_data ? 32'(i) : $urandom);
    r_req = 1'b1;
    send_word($urandom);
    start_cyc = cyc;
    send_word($urandom);
    send_word({16'($urandom_range(0, 65535)), port});
    send_word(size);
    send_word(info);
    for (int i = 0; i < n_pay; i++) begin
      send_word(pay[i]);
      if (valid && i == N - 1) begin
        exp_addr_q.push_back({1'b0, info[30:0]});
        exp_eof_q.push_back(info[31]);
        for (int k = 0; k < N; k++) exp_data_q.push_back(pay[k]);
        exp_ok++;
        if (info[31]) exp_fs = ~exp_fs;
      end
    end
    for (int i = 0; i < extra; i++) send_word($urandom);
    if (!valid) exp_drop++;
    @(negedge clk);
    r_enable = 1'b0;
    r_req    = 1'b0;
  endtask

  // Waits for the block and the engine to settle, then compares counters to the model.
  task automatic wait_quiet(input string tag);
    int t = 0;
    while ((r_ack !== 1'b1 || eng_active || exp_addr_q.size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      checks++;
      errors++;
      $display("FAIL %s_quiet_timeout actual=pending %0d required=0", tag, exp_addr_q.size());
      exp_addr_q.delete();
      exp_eof_q.delete();
      exp_data_q.delete();
    end
    repeat (2) @(negedge clk);
    check({tag, "_ok_cnt"}, 32'(pkt_ok_cnt), 32'(exp_ok[15:0]));
    check({tag, "_drop_cnt"}, 32'(pkt_drop_cnt), 32'(exp_drop[15:0]));
    check({tag, "_frame_select"}, 32'(frame_select), 32'(exp_fs));
    check({tag, "_r_ack"}, 32'(r_ack), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int kicks_before;
    int ack_bad;
    int rel_cyc;
    logic [15:0] port;
    logic [31:0] size;
    int n_pay;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_r_ack", 32'(r_ack), 32'd1);
    check("rst_wr_kick", 32'(wr_kick), 32'd0);
    check("rst_wr_addr", wr_addr, 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_frame_select", 32'(frame_select), 32'd0);
    check("rst_ok_cnt", 32'(pkt_ok_cnt), 32'd0);
    check("rst_drop_cnt", 32'(pkt_drop_cnt), 32'd0);

    // Plain valid packet with an index payload; also checks first-word-to-kick latency.
    send_pkt(GOOD_PORT, GOOD_SIZE, 32'h0000_1000, N, 0, 1'b1);
    wait_quiet("valid");
    check("kick_latency", 32'(kick_cyc - start_cyc), 32'(KICK_LAT));

    // End-of-frame packet flips frame_select.
    send_pkt(GOOD_PORT, GOOD_SIZE, 32'h8000_2000, N, 0, 1'b0);
    wait_quiet("eof");

    // Header rejections, then a valid packet must still commit.
    kicks_before = kick_cnt;
    send_pkt(16'h5000, GOOD_SIZE, 32'h0000_3000, N, 0, 1'b0);
    wait_quiet("bad_port");
    send_pkt(GOOD_PORT, 32'h0000_0204, 32'h0000_3000, N, 0, 1'b0);
    wait_quiet("bad_size");
    check("no_kick_on_bad_hdr", 32'(kick_cnt - kicks_before), 32'd0);
    send_pkt(GOOD_PORT, GOOD_SIZE, 32'h0000_3100, N, 0, 1'b0);
    wait_quiet("after_drop");

    // Short packet: r_enable falls after 100 payload words.
    kicks_before = kick_cnt;
    send_pkt(GOOD_PORT, GOOD_SIZE, 32'h0000_4000, 100, 0, 1'b0);
    wait_quiet("short");
    check("no_kick_on_short", 32'(kick_cnt - kicks_before), 32'd0);

    // Overlong packet: trailing words are ignored, packet commits.
    send_pkt(GOOD_PORT, GOOD_SIZE, 32'h8000_5000, N, 7, 1'b0);
    wait_quiet("long");

    // Engine busy when the packet completes: kick waits, r_ack stays low.
    tb_busy = 1'b1;
    kicks_before = kick_cnt;
    send_pkt(GOOD_PORT, GOOD_SIZE, 32'h0000_6000, N, 0, 1'b0);
    ack_bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (r_ack !== 1'b0) ack_bad++;
    end
    check("busy_r_ack_low", 32'(ack_bad), 32'd0);
    check("busy_no_kick", 32'(kick_cnt - kicks_before), 32'd0);
    tb_busy = 1'b0;
    rel_cyc = cyc;
    wait_quiet("busy");
    check("busy_one_kick", 32'(kick_cnt - kicks_before), 32'd1);
    check("busy_kick_after_release", 32'(kick_cyc > rel_cyc), 32'd1);

    // Randomized mix of good, bad-header, short and overlong packets.
    for (int p = 0; p < 8; p++) begin
      port  = ($urandom_range(0, 4) == 0) ? 16'($urandom_range(0, 65535)) : GOOD_PORT;
      size  = ($urandom_range(0, 4) == 0) ? 32'h0000_0204 : GOOD_SIZE;
      n_pay = ($urandom_range(0, 4) == 0) ? $urandom_range(1, N - 1) : N;
      send_pkt(port, size, {1'($urandom_range(0, 1)), 31'($urandom)},
               n_pay, $urandom_range(0, 3), 1'b0);
      wait_quiet("rand");
    end

    // Reset in the middle of the payload of a good packet.
    if (exp_fs == 1'b0) begin
      send_pkt(GOOD_PORT, GOOD_SIZE, 32'h8000_7000, N, 0, 1'b0);
      wait_quiet("pre_rst");
    end
    kicks_before = kick_cnt;
    wait_ack();
    repeat (2) @(negedge clk);
    send_word($urandom);
    send_word($urandom);
    send_word({16'h0, GOOD_PORT});
    send_word(GOOD_SIZE);
    send_word(32'h0000_7700);
    for (int i = 0; i < 100; i++) send_word($urandom);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    r_enable = 1'b0;
    rst = 1'b0;
    exp_ok   = 0;
    exp_drop = 0;
    exp_fs   = 1'b0;
    @(negedge clk);
    check("midrst_r_ack", 32'(r_ack), 32'd1);
    check("midrst_ok_cnt", 32'(pkt_ok_cnt), 32'd0);
    check("midrst_drop_cnt", 32'(pkt_drop_cnt), 32'd0);
    check("midrst_frame_select", 32'(frame_select), 32'd0);
    repeat (300) @(negedge clk);
    check("midrst_no_kick", 32'(kick_cnt - kicks_before), 32'd0);

    // Recovery after reset.
    send_pkt(GOOD_PORT, GOOD_SIZE, 32'h0000_0800, N, 0, 1'b1);
    wait_quiet("post_rst");
    check("post_rst_latency", 32'(kick_cyc - start_cyc), 32'(KICK_LAT));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
